div_issue: RTL and testbench
============================

DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning max BUSY cycles awaiting div_resultRDY before abort.
REQ-002 SHALL have clock  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid  input  1  divide request present.
REQ-005 SHALL have req_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have req_dividend, req_divisor  input  32 each  signed two's-complement operands.
REQ-007 SHALL have req_rd  input  5  destination register tag.
REQ-008 SHALL have div_start  output  1  one-cycle start pulse to the divider, driving its ctrl_DIV.
REQ-009 SHALL have div_operandA, div_operandB  output  32 each  operands held stable to the divider.
REQ-010 SHALL have div_result  input  32  divider quotient.
REQ-011 SHALL have div_resultRDY  input  1  divider done.
REQ-012 SHALL have div_exception  input  1  divider divide-by-zero flag.
REQ-013 SHALL have wb_valid, wb_data (32), wb_rd (5), wb_exception  output  completed result to writeback.
REQ-014 SHALL have wb_ready  input  1  writeback consumes result.
REQ-015 SHALL have stall  output  1  pipeline hold, high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, START, BUSY, DONE.
REQ-017 SHALL assert req_ready only in IDLE; handshake is req_valid and req_ready high in the same cycle.
REQ-018 On accept, SHALL register dividend, divisor and rd, then enter START.
REQ-019 SHALL drive div_operandA/B from the registered operands in every state; they SHALL change only on accept.
REQ-020 In START, SHALL assert div_start for exactly one cycle, clear the timeout counter, then enter BUSY.
REQ-021 SHALL sample div_resultRDY only in BUSY; any assertion in IDLE, START or DONE SHALL be ignored.
REQ-022 In BUSY with div_resultRDY high, SHALL capture wb_data=div_result and wb_exception=div_exception, then enter DONE.
REQ-023 In BUSY, the 6-bit timeout counter SHALL increment each cycle; when it reaches TIMEOUT without div_resultRDY, SHALL enter DONE with wb_data=0 and wb_exception=1.
REQ-024 If div_resultRDY and the timeout occur in the same cycle, div_resultRDY SHALL win.
REQ-025 In DONE, SHALL hold wb_valid=1 and wb_data/wb_rd/wb_exception stable until wb_ready is high, then enter IDLE on that edge.
REQ-026 wb_valid SHALL be 1 only in DONE.
REQ-027 A req_valid arriving outside IDLE SHALL not be accepted and SHALL not disturb the operation in flight.
REQ-028 Nominal latency, accept to wb_valid, SHALL be 2 + divider cycles, i.e. 34 clocks with a 32-iteration divider.

Reset
REQ-029 On reset_n low, SHALL asynchronously enter IDLE and clear all registers.
REQ-030 While in reset, SHALL drive req_ready=0, div_start=0, wb_valid=0, wb_exception=0, stall=0, and wb_data, wb_rd, div_operandA and div_operandB all 0.
REQ-031 Reset mid-operation SHALL abandon the operation with no writeback.
REQ-032 The first cycle after reset release SHALL be IDLE with req_ready=1.

Configuration
REQ-033 SHALL support macro DIV_ZERO_SKIP_EN.
REQ-034 With DIV_ZERO_SKIP_EN defined, an accepted request with divisor 0 SHALL go directly to DONE with wb_data=0 and wb_exception=1, with no div_start.
REQ-035 With DIV_ZERO_SKIP_EN defined, the divide-by-zero result of REQ-034 SHALL reach wb_valid one cycle after accept.
REQ-036 Without DIV_ZERO_SKIP_EN, a divisor of 0 SHALL follow the normal START/BUSY path, and the exception SHALL come from div_exception.

Verification
REQ-037 Accept 100/7 rd=5 -> div_start pulses one cycle; wb_valid at cycle 34 with wb_data=14, wb_rd=5, wb_exception=0.
REQ-038 Accept -100/7 -> wb_data=0xFFFFFFF2; hold wb_ready=0 for 3 cycles -> wb outputs stable, stall=1 throughout.
REQ-039 Divisor 0: with macro -> wb_exception=1 one cycle after accept, no div_start; without macro -> wb_exception=1 after the BUSY path.
REQ-040 Stub divider never asserts div_resultRDY -> DONE after 40 BUSY cycles with wb_data=0 and wb_exception=1.
REQ-041 Pulse reset_n low at BUSY cycle 10 -> immediate IDLE, wb_valid never asserts; next request completes correctly.
REQ-042 req_valid held high during BUSY with new operands -> not accepted; div_operandA/B unchanged.

Source files
------------

// File: rtl/div_issue_if.sv
// Signal bundle between div_issue and its neighbours: issue-side request,
// divider control/result, and writeback result.
`timescale 1ns/1ps
interface div_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic [4:0]  req_rd;

  logic        div_start;
  logic [31:0] div_operandA;
  logic [31:0] div_operandB;
  logic [31:0] div_result;
  logic        div_resultRDY;
  logic        div_exception;

  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_exception;
  logic        wb_ready;

  logic        stall;

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_rd,
    input  div_result, div_resultRDY, div_exception, wb_ready,
    output req_ready, div_start, div_operandA, div_operandB,
    output wb_valid, wb_data, wb_rd, wb_exception, stall
  );

  modport master (
    output req_valid, req_dividend, req_divisor, req_rd,
    output div_result, div_resultRDY, div_exception, wb_ready,
    input  req_ready, div_start, div_operandA, div_operandB,
    input  wb_valid, wb_data, wb_rd, wb_exception, stall
  );
endinterface

// File: rtl/div_issue.sv
// Issue/sequencing wrapper around a multi-cycle signed divider with timeout.
// Optional macro DIV_ZERO_SKIP_EN short-circuits divide-by-zero straight to writeback.
`timescale 1ns/1ps
module div_issue #(
  parameter int TIMEOUT = 40
) (
  input  logic       clock,
  input  logic       reset_n,
  div_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  localparam logic [5:0] TMO_LIMIT = 6'(TIMEOUT);

  state_t      state;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [4:0]  rd_q;
  logic [31:0] wb_data_q;
  logic        wb_exc_q;
  logic [5:0]  tmo_cnt;
  logic        div_start_q;
  logic        wb_valid_q;
  logic        stall_q;
  logic        accept;
  logic        skip_zero;

  assign accept = bus.req_valid && bus.req_ready;

`ifdef DIV_ZERO_SKIP_EN
  assign skip_zero = (bus.req_divisor == '0);
`else
  assign skip_zero = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      rd_q        <= '0;
      wb_data_q   <= '0;
      wb_exc_q    <= 1'b0;
      tmo_cnt     <= '0;
      div_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opa_q   <= bus.req_dividend;
            opb_q   <= bus.req_divisor;
            rd_q    <= bus.req_rd;
            stall_q <= 1'b1;
            if (skip_zero) begin
              wb_data_q  <= '0;
              wb_exc_q   <= 1'b1;
              wb_valid_q <= 1'b1;
              state      <= DONE;
            end else begin
              div_start_q <= 1'b1;
              state       <= START;
            end
          end
        end
        START: begin
          div_start_q <= 1'b0;
          tmo_cnt     <= '0;
          state       <= BUSY;
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + 6'd1;
          // A result arriving on the timeout cycle still counts as a real result.
          if (bus.div_resultRDY) begin
            wb_data_q  <= bus.div_result;
            wb_exc_q   <= bus.div_exception;
            wb_valid_q <= 1'b1;
            state      <= DONE;
          end else if (tmo_cnt + 6'd1 == TMO_LIMIT) begin
            wb_data_q  <= '0;
            wb_exc_q   <= 1'b1;
            wb_valid_q <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            stall_q    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by reset_n so the block never advertises readiness while held in reset,
  // yet is ready in the very first cycle after release.
  assign bus.req_ready    = reset_n && (state == IDLE);
  assign bus.div_start    = div_start_q;
  assign bus.div_operandA = opa_q;
  assign bus.div_operandB = opb_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_rd        = rd_q;
  assign bus.wb_exception = wb_exc_q;
  assign bus.stall        = stall_q;

endmodule

// File: tb/tb_div_issue.sv
// Self-checking bench for div_issue: stub divider with programmable latency,
// cycle-count transaction model, per-cycle compare plus directed literal checks.
`timescale 1ns/1ps
module tb_div_issue;
  localparam int TIMEOUT = 40;
  localparam int NEVER   = 1000;
`ifdef DIV_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_start = 0;

  div_issue_if bus();

  div_issue #(.TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub divider: raises div_resultRDY in the stub_delay-th cycle after div_start.
  int          stub_delay = 32;
  int          stub_cnt;
  logic        stub_force = 1'b0;
  logic [31:0] stub_a, stub_b;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stub_cnt = 0;
      bus.div_resultRDY <= 1'b0;
      bus.div_result    <= '0;
      bus.div_exception <= 1'b0;
    end else begin
      if (bus.div_start) begin
        stub_cnt = stub_delay;
        stub_a   = bus.div_operandA;
        stub_b   = bus.div_operandB;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
      end
      if (stub_cnt == 1) begin
        bus.div_resultRDY <= 1'b1;
        bus.div_result    <= (stub_b == '0) ? 32'd0 : 32'($signed(stub_a) / $signed(stub_b));
        bus.div_exception <= (stub_b == '0);
      end else if (stub_force) begin
        bus.div_resultRDY <= 1'b1;
        bus.div_result    <= 32'h1234_5678;
        bus.div_exception <= 1'b0;
      end else begin
        bus.div_resultRDY <= 1'b0;
        bus.div_result    <= 32'hDEAD_BEEF;
        bus.div_exception <= 1'b1;
      end
    end
  end

  // Transaction model: m_cyc is the cycle index since the accept cycle (accept = 0).
  bit          m_busy, m_skip;
  int          m_cyc, m_lat;
  logic [31:0] m_opa, m_opb, m_data;
  logic [4:0]  m_rd;
  logic        m_exc;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_skip = 1'b0; m_cyc = 0; m_lat = 0;
      m_opa = '0; m_opb = '0; m_rd = '0;
    end else if (!m_busy) begin
      if (bus.req_valid) begin
        m_busy = 1'b1;
        m_cyc  = 1;
        m_opa  = bus.req_dividend;
        m_opb  = bus.req_divisor;
        m_rd   = bus.req_rd;
        m_skip = SKIP && (m_opb == '0);
        if (m_skip) begin
          m_lat = 1; m_data = '0; m_exc = 1'b1;
        end else if (stub_delay <= TIMEOUT) begin
          m_lat  = stub_delay + 2;
          m_data = (m_opb == '0) ? 32'd0 : 32'($signed(m_opa) / $signed(m_opb));
          m_exc  = (m_opb == '0);
        end else begin
          m_lat = TIMEOUT + 2; m_data = '0; m_exc = 1'b1;
        end
      end
    end else if (m_cyc >= m_lat && bus.wb_ready) begin
      m_busy = 1'b0;
    end else begin
      m_cyc++;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("req_ready", 32'(bus.req_ready), 32'(!m_busy));
      check("stall", 32'(bus.stall), 32'(m_busy));
      check("div_start", 32'(bus.div_start), 32'(m_busy && m_cyc == 1 && !m_skip));
      check("wb_valid", 32'(bus.wb_valid), 32'(m_busy && m_cyc >= m_lat));
      check("div_operandA", bus.div_operandA, m_opa);
      check("div_operandB", bus.div_operandB, m_opb);
      if (m_busy && m_cyc >= m_lat) begin
        check("wb_data", bus.wb_data, m_data);
        check("wb_rd", 32'(bus.wb_rd), 32'(m_rd));
        check("wb_exception", 32'(bus.wb_exception), 32'(m_exc));
      end
      if (bus.div_start) n_start++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.req_valid    = 1'b1;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    bus.req_rd       = rd;
    tick(1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_wb(input int start, output int lat, output logic [31:0] d,
                         output logic [4:0] rd, output logic e);
    lat = start;
    while (!bus.wb_valid && lat < 200) begin
      tick(1);
      lat++;
    end
    d = bus.wb_data; rd = bus.wb_rd; e = bus.wb_exception;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd_in,
                        output int lat, output logic [31:0] d, output logic [4:0] rd, output logic e);
    issue(a, b, rd_in);
    wait_wb(1, lat, d, rd, e);
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, s0;
    logic [31:0] d;
    logic [4:0]  rd;
    logic        e;

    bus.req_valid = 1'b0; bus.req_dividend = '0; bus.req_divisor = '0; bus.req_rd = '0;
    bus.wb_ready = 1'b1;

    #2;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_div_start", 32'(bus.div_start), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_exception", 32'(bus.wb_exception), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    check("rst_operandA", bus.div_operandA, 32'd0);
    check("rst_operandB", bus.div_operandB, 32'd0);
    tick(3);
    reset_n = 1'b1;
    #1;
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // 100 / 7 nominal
    s0 = n_start;
    run_op(32'd100, 32'd7, 5'd5, lat, d, rd, e);
    check("t1_latency", 32'(lat), 32'd34);
    check("t1_data", d, 32'd14);
    check("t1_rd", 32'(rd), 32'd5);
    check("t1_exc", 32'(e), 32'd0);
    check("t1_start_pulses", 32'(n_start - s0), 32'd1);

    // -100 / 7 with writeback back-pressure
    bus.wb_ready = 1'b0;
    issue(-32'sd100, 32'd7, 5'd9);
    wait_wb(1, lat, d, rd, e);
    check("t2_latency", 32'(lat), 32'd34);
    check("t2_data", d, 32'hFFFF_FFF2);
    tick(3);
    check("t2_held_data", bus.wb_data, 32'hFFFF_FFF2);
    check("t2_held_stall", 32'(bus.stall), 32'd1);
    check("t2_held_valid", 32'(bus.wb_valid), 32'd1);
    bus.wb_ready = 1'b1;
    tick(1);
    check("t2_released_valid", 32'(bus.wb_valid), 32'd0);
    check("t2_released_ready", 32'(bus.req_ready), 32'd1);

    // divide by zero
    s0 = n_start;
    run_op(32'd55, 32'd0, 5'd3, lat, d, rd, e);
    check("t3_data", d, 32'd0);
    check("t3_exc", 32'(e), 32'd1);
`ifdef DIV_ZERO_SKIP_EN
    check("t3_latency", 32'(lat), 32'd1);
    check("t3_start_pulses", 32'(n_start - s0), 32'd0);
`else
    check("t3_latency", 32'(lat), 32'd34);
    check("t3_start_pulses", 32'(n_start - s0), 32'd1);
`endif

    // divider never answers: timeout after 40 BUSY cycles
    stub_delay = NEVER;
    run_op(32'd1, 32'd1, 5'd7, lat, d, rd, e);
    check("t4_latency", 32'(lat), 32'd42);
    check("t4_data", d, 32'd0);
    check("t4_exc", 32'(e), 32'd1);

    // result on the timeout cycle wins
    stub_delay = 40;
    run_op(32'd81, 32'd9, 5'd2, lat, d, rd, e);
    check("t5_latency", 32'(lat), 32'd42);
    check("t5_data", d, 32'd9);
    check("t5_exc", 32'(e), 32'd0);

    // result one cycle late: timeout, then stray RDY in DONE ignored
    stub_delay = 41;
    bus.wb_ready = 1'b0;
    issue(32'd81, 32'd9, 5'd4);
    wait_wb(1, lat, d, rd, e);
    check("t6_latency", 32'(lat), 32'd42);
    tick(3);
    check("t6_held_data", bus.wb_data, 32'd0);
    check("t6_held_exc", 32'(bus.wb_exception), 32'd1);
    bus.wb_ready = 1'b1;
    tick(1);

    // stray RDY in IDLE and START ignored
    stub_delay = 32;
    stub_force = 1'b1;
    tick(3);
    issue(32'd200, -32'sd8, 5'd11);
    stub_force = 1'b0;
    wait_wb(1, lat, d, rd, e);
    check("t7_latency", 32'(lat), 32'd34);
    check("t7_data", d, 32'hFFFF_FFE7);
    tick(1);

    // reset in BUSY cycle 10 abandons the op
    issue(32'd100, 32'd7, 5'd5);
    tick(10);
    reset_n = 1'b0;
    #1;
    check("t8_rst_stall", 32'(bus.stall), 32'd0);
    check("t8_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("t8_rst_operandA", bus.div_operandA, 32'd0);
    tick(2);
    reset_n = 1'b1;
    #1;
    check("t8_post_rst_ready", 32'(bus.req_ready), 32'd1);
    tick(40);
    run_op(-32'sd7, 32'd2, 5'd31, lat, d, rd, e);
    check("t8_latency", 32'(lat), 32'd34);
    check("t8_data", d, 32'hFFFF_FFFD);
    check("t8_rd", 32'(rd), 32'd31);

    // new request during BUSY is refused and leaves operands alone
    issue(32'd1000, 32'd10, 5'd6);
    tick(3);
    bus.req_valid = 1'b1; bus.req_dividend = 32'd77; bus.req_divisor = 32'd3; bus.req_rd = 5'd1;
    tick(5);
    check("t9_operandA", bus.div_operandA, 32'd1000);
    check("t9_operandB", bus.div_operandB, 32'd10);
    check("t9_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    wait_wb(9, lat, d, rd, e);
    check("t9_latency", 32'(lat), 32'd34);
    check("t9_data", d, 32'd100);
    check("t9_rd", 32'(rd), 32'd6);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
